// File: rtl/flow_fifo_pkg.sv
// Shared defaults and pause-state encoding for the flow_fifo lane buffer.
package flow_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_THRESH  = 6;
  localparam int DEF_AE_THRESH  = 2;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } pause_state_e;

endpackage

// File: rtl/flow_fifo_mem.sv
// Storage array for flow_fifo: one synchronous write port and one registered read port.
module flow_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; it only holds data behind the pointers, and a reset
  // would turn it from a RAM into a large bank of resettable flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A same-edge write to rd_addr (full FIFO, read+write) returns the old word.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/flow_fifo.sv
// Lane FIFO with registered status flags and hysteretic pause for the data-flow controller.
// Define FLOW_FIFO_STICKY_ERR_EN to make fifo_error hold until reset instead of pulsing.
module flow_fifo
  import flow_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  Fifo_full,
  output logic                  almost_full,
  output logic                  fifo_empty,
  output logic                  almost_empty,
  output logic                  fifo_pause,
  output logic                  fifo_error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_LVL = CW'(1 << ADDR_WIDTH);
  localparam logic [CW-1:0] AF_LVL    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  wr_accept, rd_accept, wr_reject, rd_reject, err_next;
  pause_state_e          pause_state, pause_next;

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_accept  = read && (count != '0);
    wr_accept  = write && ((count != DEPTH_LVL) || rd_accept);
    rd_reject  = read && !rd_accept;
    wr_reject  = write && !wr_accept;
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    pause_next = pause_state;
    if (pause_state == RUN && count_next >= AF_LVL)
      pause_next = PAUSE;
    else if (pause_state == PAUSE && count_next <= AE_LVL)
      pause_next = RUN;
  end

`ifdef FLOW_FIFO_STICKY_ERR_EN
  assign err_next = fifo_error | wr_reject | rd_reject;
`else
  assign err_next = wr_reject | rd_reject;
`endif

  // NOTE: state updates use non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid_out    <= 1'b0;
      Fifo_full    <= 1'b0;
      almost_full  <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_empty <= 1'b1;
      pause_state  <= RUN;
      fifo_error   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      valid_out    <= rd_accept;
      // Flags look at the next occupancy so they line up with the accepting edge.
      Fifo_full    <= (count_next == DEPTH_LVL);
      almost_full  <= (count_next >= AF_LVL);
      fifo_empty   <= (count_next == '0);
      almost_empty <= (count_next <= AE_LVL);
      pause_state  <= pause_next;
      fifo_error   <= err_next;
    end
  end

  assign fifo_pause = (pause_state == PAUSE);

  flow_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept && !reset),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_accept && !reset),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_flow_fifo.sv
// Directed scoreboard bench for flow_fifo at default parameters (depth 8, AF 6, AE 2).
module tb_flow_fifo;

`ifdef FLOW_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk, reset, write, read;
  logic [7:0] data_in, data_out;
  logic       valid_out, Fifo_full, almost_full, fifo_empty, almost_empty, fifo_pause, fifo_error;

  int passed = 0;
  int total  = 0;
  bit err_seen = 1'b0;
  logic [7:0] exp_q [$];

  flow_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .Fifo_full    (Fifo_full),
    .almost_full  (almost_full),
    .fifo_empty   (fifo_empty),
    .almost_empty (almost_empty),
    .fifo_pause   (fifo_pause),
    .fifo_error   (fifo_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_flags(input string tag, input bit full, input bit af, input bit empty,
                             input bit ae, input bit pause, input bit err);
    check({tag, "_full"},  32'(Fifo_full),    32'(full));
    check({tag, "_af"},    32'(almost_full),  32'(af));
    check({tag, "_empty"}, 32'(fifo_empty),   32'(empty));
    check({tag, "_ae"},    32'(almost_empty), 32'(ae));
    check({tag, "_pause"}, 32'(fifo_pause),   32'(pause));
    check({tag, "_err"},   32'(fifo_error),   32'(err));
  endtask

  // Expected fifo_error when this cycle's own request raised (now=1) or did not raise an error.
  function automatic bit err_exp(input bit now);
    return STICKY ? err_seen : now;
  endfunction

  task automatic step(input bit w, input bit r, input logic [7:0] d);
    write = w; read = r; data_in = d;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    err_seen = 1'b0;
  endtask

  // Monitor: every presented word must match the head of the scoreboard.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          exp = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    write = 1'b0; read = 1'b0; data_in = 8'h00; reset = 1'b1;
    do_reset();
    check_flags("rst", 0, 0, 1, 1, 0, 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_data",  32'(data_out),  0);

    // Fill 0x11..0x18.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 8'(8'h10 + k));
      check_flags($sformatf("fill%0d", k), k == 8, k >= 6, 0, k <= 2, k >= 6, 0);
    end

    // Drain in order; pause holds until occupancy falls to 2.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d_valid", i), 32'(valid_out), 1);
      check_flags($sformatf("drain%0d", i), 0, (7 - i) >= 6, i == 7, (7 - i) <= 2, (7 - i) > 2, 0);
    end

    // Refill, then overflow with 0x99 which must never come out.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 8'(8'h20 + k));
    err_seen = 1'b1;
    step(1'b1, 1'b0, 8'h99);
    check_flags("ovf", 1, 1, 0, 0, 1, 1);
    step(1'b0, 1'b0, 8'h00);
    check_flags("ovf_after", 1, 1, 0, 0, 1, err_exp(0));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h21 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    check_flags("ovf_drained", 0, 0, 1, 1, 0, err_exp(0));

    // Read on empty together with a write of 0xA5: write taken, read rejected.
    step(1'b1, 1'b1, 8'hA5);
    check("udf_valid", 32'(valid_out), 0);
    check_flags("udf", 0, 0, 0, 1, 0, 1);
    exp_q.push_back(8'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("udf_read_valid", 32'(valid_out), 1);
    check_flags("udf_read", 0, 0, 1, 1, 0, err_exp(0));

    // Reset clears a sticky error; then read+write at full across the wrap.
    do_reset();
    check_flags("rst2", 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 8'(8'h30 + k));
    check_flags("full2", 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(i < 8 ? 8'(8'h31 + i) : 8'(8'h40 + i - 8));
      step(1'b1, 1'b1, 8'(8'h40 + i));
      check($sformatf("rw%0d_valid", i), 32'(valid_out), 1);
      check_flags($sformatf("rw%0d", i), 1, 1, 0, 0, 1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h42 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    check_flags("rw_drained", 0, 0, 1, 1, 0, 0);

    // Reset with occupancy 5 and write held high.
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 8'(8'h50 + k));
    check_flags("occ5", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    reset = 1'b0;
    check_flags("rst3", 0, 0, 1, 1, 0, 0);
    check("rst3_valid", 32'(valid_out), 0);
    check("rst3_data",  32'(data_out),  0);
    step(1'b1, 1'b0, 8'h66);
    check_flags("post_rst_wr", 0, 0, 0, 1, 0, 0);
    exp_q.push_back(8'h66);
    step(1'b0, 1'b1, 8'h00);
    check_flags("post_rst_rd", 0, 0, 1, 1, 0, 0);

    step(1'b0, 1'b0, 8'h00);
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
